// File: rtl/lc3b_types.sv
`default_nettype none
// ============================================================================
// Package     : lc3b_types
// Description : Shared LC-3b word types plus direct-mapped cache geometry,
//               state encoding and word select / byte merge helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [1:0]   lc3b_mem_wmask;

  typedef logic [8:0]   lc3b_c_tag;
  typedef logic [2:0]   lc3b_c_index;
  typedef logic [2:0]   lc3b_c_offset;
  typedef logic [127:0] lc3b_c_line;

  localparam int c_NUM_LINES = 8;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WRITEBACK = 2'd1,
    S_FILL      = 2'd2
  } cache_state_t;

  // Pick the 16-bit word at a word offset within a line.
  function automatic lc3b_word get_word(input lc3b_c_line line, input lc3b_c_offset off);
    return line[{off, 4'b0000} +: 16];
  endfunction

  // Merge enabled byte lanes of a word into a line; [1] is the high byte.
  function automatic lc3b_c_line merge_word(input lc3b_c_line line, input lc3b_c_offset off,
                                            input lc3b_word wdata, input lc3b_mem_wmask be);
    lc3b_c_line r;
    r = line;
    if (be[0]) r[{off, 4'b0000} +: 8] = wdata[7:0];
    if (be[1]) r[{off, 4'b1000} +: 8] = wdata[15:8];
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cache_array.sv
`default_nettype none
// ============================================================================
// Module      : cache_array
// Description : 8-entry line storage (data, tag, valid, dirty). One shared
//               index for the combinational read port and the write port.
//               Only valid/dirty are cleared by reset.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_array
  import lc3b_types::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  lc3b_c_index i_index,
  input  logic        i_we_line,
  input  lc3b_c_line  i_line,
  input  logic        i_we_tag,
  input  lc3b_c_tag   i_tag,
  input  logic        i_we_valid,
  input  logic        i_valid,
  input  logic        i_we_dirty,
  input  logic        i_dirty,
  output lc3b_c_line  o_line,
  output lc3b_c_tag   o_tag,
  output logic        o_valid,
  output logic        o_dirty
);

  lc3b_c_line             r_data [c_NUM_LINES];
  lc3b_c_tag              r_tag  [c_NUM_LINES];
  logic [c_NUM_LINES-1:0] r_valid;
  logic [c_NUM_LINES-1:0] r_dirty;

  // Data and tag storage: no reset needed, invalid lines are never read out as hits.
  always_ff @(posedge clk) begin
    if (i_we_line) r_data[i_index] <= i_line;
    if (i_we_tag)  r_tag[i_index]  <= i_tag;
  end

  // Status bits: cleared asynchronously so a reset invalidates every line at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else begin
      if (i_we_valid) r_valid[i_index] <= i_valid;
      if (i_we_dirty) r_dirty[i_index] <= i_dirty;
    end
  end

  assign o_line  = r_data[i_index];
  assign o_tag   = r_tag[i_index];
  assign o_valid = r_valid[i_index];
  assign o_dirty = r_dirty[i_index];

endmodule
`default_nettype wire

// File: rtl/dm_cache.sv
`default_nettype none
// ============================================================================
// Module      : dm_cache
// Description : Direct-mapped, write-back, write-allocate cache, 8 lines of
//               16 bytes. Hits complete combinationally in IDLE; misses go
//               through WRITEBACK (dirty victim) and FILL, then hit.
// Revision    : 1.0 - initial release
// ============================================================================
module dm_cache
  import lc3b_types::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          mem_read,
  input  logic          mem_write,
  input  lc3b_mem_wmask mem_byte_enable,
  input  lc3b_word      mem_address,
  input  lc3b_word      mem_wdata,
  output logic          mem_resp,
  output lc3b_word      mem_rdata,
  output logic          pmem_read,
  output logic          pmem_write,
  output lc3b_word      pmem_address,
  output lc3b_c_line    pmem_wdata,
  input  lc3b_c_line    pmem_rdata,
  input  logic          pmem_resp
);

  cache_state_t r_state;
  cache_state_t w_state_next;

  lc3b_c_tag    w_tag;
  lc3b_c_index  w_index;
  lc3b_c_offset w_off;
  logic         w_req;
  logic         w_hit;

  lc3b_c_line   w_line;
  lc3b_c_tag    w_line_tag;
  logic         w_line_valid;
  logic         w_line_dirty;

  logic         w_we_line;
  lc3b_c_line   w_line_in;
  logic         w_we_tag;
  logic         w_we_valid;
  logic         w_valid_in;
  logic         w_we_dirty;
  logic         w_dirty_in;

  assign w_tag   = mem_address[15:7];
  assign w_index = mem_address[6:4];
  assign w_off   = mem_address[3:1];
  assign w_req   = mem_read | mem_write;
  assign w_hit   = w_line_valid && (w_line_tag == w_tag);

  cache_array u_array (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_index    (w_index),
    .i_we_line  (w_we_line),
    .i_line     (w_line_in),
    .i_we_tag   (w_we_tag),
    .i_tag      (w_tag),
    .i_we_valid (w_we_valid),
    .i_valid    (w_valid_in),
    .i_we_dirty (w_we_dirty),
    .i_dirty    (w_dirty_in),
    .o_line     (w_line),
    .o_tag      (w_line_tag),
    .o_valid    (w_line_valid),
    .o_dirty    (w_line_dirty)
  );

  // State register; reset drops any in-flight writeback/fill immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // Next state, hit handling, array write controls and memory-side outputs.
  always_comb begin
    w_state_next = r_state;
    mem_resp     = 1'b0;
    mem_rdata    = '0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    w_we_line    = 1'b0;
    w_line_in    = w_line;
    w_we_tag     = 1'b0;
    w_we_valid   = 1'b0;
    w_valid_in   = 1'b0;
    w_we_dirty   = 1'b0;
    w_dirty_in   = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (w_req) begin
          if (w_hit) begin
            mem_resp = 1'b1;
            // A simultaneous read+write is serviced as a write.
            if (mem_write) begin
              w_we_line  = 1'b1;
              w_line_in  = merge_word(w_line, w_off, mem_wdata, mem_byte_enable);
              w_we_dirty = 1'b1;
              w_dirty_in = 1'b1;
            end else begin
              mem_rdata = get_word(w_line, w_off);
            end
          end else if (w_line_valid && w_line_dirty) begin
            w_state_next = S_WRITEBACK;
          end else begin
            w_state_next = S_FILL;
          end
        end
      end

      S_WRITEBACK: begin
        pmem_write   = 1'b1;
        pmem_address = {w_line_tag, w_index, 4'b0000};
        pmem_wdata   = w_line;
        if (pmem_resp) begin
          w_we_dirty   = 1'b1;
          w_dirty_in   = 1'b0;
          w_state_next = S_FILL;
        end
      end

      S_FILL: begin
        pmem_read    = 1'b1;
        pmem_address = {mem_address[15:4], 4'b0000};
        if (pmem_resp) begin
          w_we_line    = 1'b1;
          w_line_in    = pmem_rdata;
          w_we_tag     = 1'b1;
          w_we_valid   = 1'b1;
          w_valid_in   = 1'b1;
          w_we_dirty   = 1'b1;
          w_dirty_in   = 1'b0;
          w_state_next = S_IDLE;
        end
      end

      default: w_state_next = S_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_dm_cache.sv
`default_nettype none
// ============================================================================
// Module      : tb_dm_cache
// Description : Self-checking bench for dm_cache. A behavioural cache model
//               and a physical memory array predict hits, evictions, bus
//               addresses/data and read data for directed and random traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dm_cache;

  logic         clk;
  logic         rst_n;
  logic         mem_read;
  logic         mem_write;
  logic [1:0]   mem_byte_enable;
  logic [15:0]  mem_address;
  logic [15:0]  mem_wdata;
  logic         mem_resp;
  logic [15:0]  mem_rdata;
  logic         pmem_read;
  logic         pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: physical memory by line address, cache contents by index.
  logic [127:0] phys    [4096];
  logic         m_valid [8];
  logic         m_dirty [8];
  logic [8:0]   m_tag   [8];
  logic [127:0] m_line  [8];

  dm_cache dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_byte_enable (mem_byte_enable),
    .mem_address     (mem_address),
    .mem_wdata       (mem_wdata),
    .mem_resp        (mem_resp),
    .mem_rdata       (mem_rdata),
    .pmem_read       (pmem_read),
    .pmem_write      (pmem_write),
    .pmem_address    (pmem_address),
    .pmem_wdata      (pmem_wdata),
    .pmem_rdata      (pmem_rdata),
    .pmem_resp       (pmem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 8; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
  endtask

  // One CPU request: service the memory side and check every observable step.
  task automatic do_req(input logic rd, input logic wr, input logic [15:0] a,
                        input logic [15:0] wd, input logic [1:0] be);
    logic [2:0]   idx;
    logic [8:0]   tg;
    int           off;
    bit           exp_hit, exp_wb, saw_wb, saw_fill, done;
    int           cyc, wb_cnt, fl_cnt, dly, fill_cyc;
    idx      = a[6:4];
    tg       = a[15:7];
    off      = int'(a[3:1]);
    exp_hit  = m_valid[idx] && (m_tag[idx] == tg);
    exp_wb   = !exp_hit && m_valid[idx] && m_dirty[idx];
    mem_read = rd; mem_write = wr; mem_address = a; mem_wdata = wd; mem_byte_enable = be;
    cyc = 0; done = 0; saw_wb = 0; saw_fill = 0; wb_cnt = 0; fl_cnt = 0; fill_cyc = 0;
    dly = int'($urandom_range(0, 3));
    while (!done && cyc < 64) begin
      @(negedge clk);
      cyc++;
      pmem_resp = 1'b0;
      chk("pmem_exclusive", 128'(pmem_read & pmem_write), 128'd0);
      if (mem_resp) begin
        done = 1;
        chk("first_cycle_resp", 128'(cyc == 1), 128'(exp_hit));
        chk("writeback_seen", 128'(saw_wb), 128'(exp_wb));
        chk("fill_seen", 128'(saw_fill), 128'(!exp_hit));
        if (saw_fill) chk("fill_to_resp", 128'(cyc - fill_cyc), 128'd1);
        if (!wr) chk("rdata", 128'(mem_rdata), 128'(m_line[idx][off*16 +: 16]));
      end else if (pmem_write) begin
        saw_wb = 1;
        if (wb_cnt == 0) begin
          chk("wb_addr", 128'(pmem_address), 128'({m_tag[idx], idx, 4'b0000}));
          chk("wb_data", pmem_wdata, m_line[idx]);
        end
        if (wb_cnt == dly) begin
          pmem_resp = 1'b1;
          phys[{m_tag[idx], idx}] = m_line[idx];
          m_dirty[idx] = 1'b0;
        end
        wb_cnt++;
      end else if (pmem_read) begin
        saw_fill = 1;
        if (fl_cnt == 0) chk("fill_addr", 128'(pmem_address), 128'({a[15:4], 4'b0000}));
        pmem_rdata = {$urandom, $urandom, $urandom, $urandom};
        if (fl_cnt == dly) begin
          pmem_resp    = 1'b1;
          pmem_rdata   = phys[a[15:4]];
          m_line[idx]  = phys[a[15:4]];
          m_tag[idx]   = tg;
          m_valid[idx] = 1'b1;
          m_dirty[idx] = 1'b0;
          fill_cyc     = cyc;
        end
        fl_cnt++;
      end
    end
    chk("req_done", 128'(done), 128'd1);
    if (done && wr) begin
      if (be[0]) m_line[idx][off*16 +: 8]     = wd[7:0];
      if (be[1]) m_line[idx][off*16 + 8 +: 8] = wd[15:8];
      m_dirty[idx] = 1'b1;
    end
    @(posedge clk);
    #1;
    mem_read = 1'b0; mem_write = 1'b0;
  endtask

  // An idle cycle, optionally with a stray pmem_resp that must be ignored.
  task automatic idle_gap(input bit spur);
    pmem_resp = spur;
    @(negedge clk);
    chk("idle_mem_resp", 128'(mem_resp), 128'd0);
    chk("idle_rdata", 128'(mem_rdata), 128'd0);
    chk("idle_pmem", 128'({pmem_read, pmem_write}), 128'd0);
    @(posedge clk);
    #1;
    pmem_resp = 1'b0;
  endtask

  initial begin
    bit found;
    int r;
    logic [15:0] a;
    rst_n = 1'b0; mem_read = 0; mem_write = 0; mem_byte_enable = 0;
    mem_address = 0; mem_wdata = 0; pmem_rdata = 0; pmem_resp = 0;
    for (int i = 0; i < 4096; i++) phys[i] = {$urandom, $urandom, $urandom, $urandom};
    model_clear();
    repeat (3) @(negedge clk);
    chk("reset_outputs", 128'({mem_resp, pmem_read, pmem_write}), 128'd0);
    chk("reset_rdata", 128'(mem_rdata), 128'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed: cold read, read hit, partial write, dirty eviction, rd+wr hit.
    do_req(1, 0, 16'h0012, 16'h0000, 2'b00);
    idle_gap(0);
    do_req(1, 0, 16'h0014, 16'h0000, 2'b00);
    idle_gap(1);
    do_req(0, 1, 16'h0012, 16'hABCD, 2'b10);
    idle_gap(0);
    do_req(1, 0, 16'h0012, 16'h0000, 2'b00);
    idle_gap(0);
    do_req(0, 1, 16'h0016, 16'h1234, 2'b00);
    idle_gap(0);
    do_req(1, 0, 16'h0092, 16'h0000, 2'b00);
    idle_gap(0);
    do_req(1, 1, 16'h0092, 16'h5A5A, 2'b11);
    idle_gap(0);
    do_req(1, 0, 16'h0092, 16'h0000, 2'b00);
    idle_gap(0);

    // Reset in the middle of a fill: pmem_read must drop without a clock edge.
    mem_read = 1'b1; mem_write = 1'b0; mem_address = 16'h0014;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      pmem_resp = 1'b0;
      if (pmem_write) begin
        pmem_resp = 1'b1;
        phys[{m_tag[1], 3'd1}] = m_line[1];
        m_dirty[1] = 1'b0;
      end else if (pmem_read) begin
        found = 1;
      end
    end
    chk("rst_fill_reached", 128'(found), 128'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_pmem", 128'({pmem_read, pmem_write}), 128'd0);
    chk("rst_async_resp", 128'(mem_resp), 128'd0);
    mem_read = 1'b0;
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    do_req(1, 0, 16'h0014, 16'h0000, 2'b00);
    idle_gap(0);

    // Random traffic over a few tags so lines are evicted often.
    for (int n = 0; n < 300; n++) begin
      a = {7'd0, 2'($urandom_range(0, 3)), 3'($urandom), 3'($urandom), 1'($urandom)};
      r = int'($urandom_range(0, 3));
      do_req(r != 2, r >= 2, a, 16'($urandom), 2'($urandom));
      if ($urandom_range(0, 3) == 0) idle_gap(1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dm_cache.md
DM_CACHE -- requirements
Module: dm_cache

Interface
REQ-001 clk  in  1  sole clock; all state updates on rising edge.
REQ-002 rst_n  in  1  asynchronous active-low reset.
REQ-003 mem_read  in  1  CPU read request; held stable until mem_resp.
REQ-004 mem_write  in  1  CPU write request; held stable until mem_resp.
REQ-005 mem_byte_enable  in  2  lc3b_mem_wmask; write byte lanes, [1]=high byte; ignored on reads.
REQ-006 mem_address  in  16  lc3b_word; byte address; tag=[15:7], index=[6:4], word offset=[3:1].
REQ-007 mem_wdata  in  16  lc3b_word; write data.
REQ-008 mem_resp  out  1  request complete, one cycle per request.
REQ-009 mem_rdata  out  16  lc3b_word; read data, valid while mem_resp=1.
REQ-010 pmem_read  out  1  line fill request to physical memory.
REQ-011 pmem_write  out  1  line writeback request to physical memory.
REQ-012 pmem_address  out  16  line address, [3:0]=0.
REQ-013 pmem_wdata  out  128  writeback line.
REQ-014 pmem_rdata  in  128  fill line, valid with pmem_resp.
REQ-015 pmem_resp  in  1  physical memory completion pulse.

Function
REQ-016 Organisation: direct-mapped, write-back, write-allocate; 8 lines x 16 bytes; per line valid, dirty, 9-bit tag.
REQ-017 States: IDLE, WRITEBACK, FILL only.
REQ-018 IDLE, no request: all outputs 0, mem_rdata 0.
REQ-019 IDLE hit (valid and tag match): mem_resp=1 combinationally in same cycle; read returns word at offset; state stays IDLE.
REQ-020 Write hit: at that edge, bytes enabled by mem_byte_enable written into line word at offset, dirty set; disabled lanes unchanged; mem_byte_enable=00 completes with no data change and dirty set.
REQ-021 Miss, line invalid or clean: next state FILL; miss, valid and dirty: next state WRITEBACK; no mem_resp on miss cycle.
REQ-022 WRITEBACK: pmem_write=1, pmem_address={stored tag, index, 4'b0}, pmem_wdata=stored line; on pmem_resp -> FILL, dirty cleared.
REQ-023 FILL: pmem_read=1, pmem_address={mem_address[15:4], 4'b0}; on pmem_resp line<=pmem_rdata, tag written, valid=1, dirty=0 -> IDLE.
REQ-024 After FILL, request completes as a hit in the first IDLE cycle (miss latency = writeback + fill + 1 cycle).
REQ-025 pmem_read and pmem_write never both 1; each held continuously until pmem_resp.
REQ-026 pmem_resp in IDLE ignored.
REQ-027 mem_read and mem_write both 1: treated as write.
REQ-028 Index wrap: addresses differing only in tag map to same line and evict each other.

Reset
REQ-029 rst_n=0: state IDLE, all valid and dirty cleared, pmem_read/pmem_write/mem_resp deasserted immediately, independent of clk.
REQ-030 Reset mid-WRITEBACK or mid-FILL aborts the transaction; line contents undefined but invalid.
REQ-031 Data and tag arrays need no reset.

Structure
REQ-032 lc3b_types gains lc3b_c_tag (9b), lc3b_c_index (3b), lc3b_c_offset (3b), lc3b_c_line (128b), and cache_state_t enum.
REQ-033 One sub-module, cache_array: 8-entry storage of data/tag/valid/dirty, one read port, one write port, async clear of valid/dirty.
REQ-034 dm_cache contains FSM, hit compare, word select, byte merge.

Verification
REQ-035 Cold read 0x0012 -> FILL pmem_address 0x0010, no writeback; after pmem_resp, mem_resp next cycle with word 1 of line.
REQ-036 Read hit 0x0014 after REQ-035 -> mem_resp same cycle, no pmem activity.
REQ-037 Write 0x0012 data 0xABCD enable 10, then read -> high byte 0xAB, low byte original; dirty set.
REQ-038 Read 0x0092 (same index, new tag) after REQ-037 -> pmem_write address 0x0010 with modified line, then pmem_read 0x0090, then mem_resp.
REQ-039 rst_n low during FILL -> pmem_read drops without clock; re-read 0x0014 misses.
REQ-040 mem_read and mem_write both high on hit -> write performed, mem_resp one cycle.
